// File: rtl/branch_redirect_ctrl_if.sv
// Branch request (EX -> controller) and fetch redirect (controller -> IF) handshakes.
// The controller uses the slave modport; the EX/fetch side uses master.
interface branch_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            br_ready;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_imm;
  logic [XLEN-1:0] br_rs1;
  logic [XLEN-1:0] br_rs2;
  logic [2:0]      br_f3;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output br_valid, br_pc, br_imm, br_rs1, br_rs2, br_f3, redirect_ready,
    input  br_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  br_valid, br_pc, br_imm, br_rs1, br_rs2, br_f3, redirect_ready,
    output br_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer: IDLE -> EVAL -> REDIRECT -> FLUSH, one branch in flight.
// Optional macro BRANCH_BTFN_PREDICT_EN: fetch predicts backward-taken/forward-not-taken.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_redirect_ctrl_if.slave bus,
  output logic                 flush,
  output logic                 misalign_err,
  output logic [CNT_W-1:0]     resolved_cnt,
  output logic [CNT_W-1:0]     redirect_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REDIRECT, S_FLUSH} state_e;

  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;
  logic [2:0]        f3_q, f3_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  res_q, res_d, rdc_q, rdc_d;

  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   new_pc;
  logic              taken;
  logic              misalign;
  logic              need_redirect;

  // Branch condition and redirect decision, all from the captured operands.
  always_comb begin
    target = pc_q + imm_q;
    taken  = 1'b0;
    case (f3_q)
      3'b000:  taken = (rs1_q == rs2_q);
      3'b001:  taken = (rs1_q != rs2_q);
      3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  taken = (rs1_q <  rs2_q);
      3'b111:  taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
    misalign = taken && (target[1:0] != 2'b00);
`ifdef BRANCH_BTFN_PREDICT_EN
    begin : btfn
      logic            predicted;
      logic [XLEN-1:0] fallthrough;
      predicted   = imm_q[XLEN-1];
      fallthrough = pc_q + XLEN'(4);
      // A misaligned taken target is never fetched; undo a backward-taken guess only.
      if (misalign) begin
        need_redirect = predicted;
        new_pc        = fallthrough;
      end else begin
        need_redirect = (taken != predicted);
        new_pc        = taken ? target : fallthrough;
      end
    end
`else
    need_redirect = taken && !misalign;
    new_pc        = target;
`endif
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    imm_d              = imm_q;
    rs1_d              = rs1_q;
    rs2_d              = rs2_q;
    f3_d               = f3_q;
    rpc_d              = rpc_q;
    fcnt_d             = fcnt_q;
    res_d              = res_q;
    rdc_d              = rdc_q;
    bus.br_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    flush              = 1'b0;
    misalign_err       = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.br_ready = 1'b1;
        if (bus.br_valid) begin
          pc_d    = bus.br_pc;
          imm_d   = bus.br_imm;
          rs1_d   = bus.br_rs1;
          rs2_d   = bus.br_rs2;
          f3_d    = bus.br_f3;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (res_q != '1) res_d = res_q + 1'b1;
        misalign_err = misalign;
        if (need_redirect) begin
          rpc_d   = new_pc;
          state_d = S_REDIRECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDIRECT: begin
        bus.redirect_valid = 1'b1;
        if (bus.redirect_ready) begin
          if (rdc_q != '1) rdc_d = rdc_q + 1'b1;
          if (FLUSH_CYCLES > 0) begin
            fcnt_d  = FLUSH_LOAD;
            state_d = S_FLUSH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (fcnt_q == 4'd0) state_d = S_IDLE;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      rpc_q   <= '0;
      fcnt_q  <= '0;
      res_q   <= '0;
      rdc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      f3_q    <= f3_d;
      rpc_q   <= rpc_d;
      fcnt_q  <= fcnt_d;
      res_q   <= res_d;
      rdc_q   <= rdc_d;
    end
  end

  assign bus.redirect_pc = rpc_q;
  assign resolved_cnt    = res_q;
  assign redirect_cnt    = rdc_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed table, random branches against
// a reference model, and a reset-during-REDIRECT sequence. Counters use CNT_W=4 to reach saturation.
module tb_branch_redirect_ctrl;
  localparam int XLEN      = 32;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    int          rdyDelay;
    logic        expRedir;
    logic [31:0] expPc;
    logic        expMis;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic misalign_err;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  int total = 0;
  int bad   = 0;
  int resolvedModel = 0;
  int redirectModel = 0;

  branch_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

  branch_redirect_ctrl #(
    .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .misalign_err(misalign_err),
    .resolved_cnt(resolved_cnt), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Reference rules: condition by funct3, target/fallthrough modulo 2^32.
  function automatic void refModel(input vec_t v, output logic redir, output logic [31:0] rpc,
                                   output logic mis);
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] fall;
    tgt  = 32'((longint'(v.pc) + longint'(v.imm)) % (longint'(1) << 32));
    fall = 32'((longint'(v.pc) + 64'd4) % (longint'(1) << 32));
    case (v.f3)
      3'd0: taken = (longint'(v.rs1) == longint'(v.rs2));
      3'd1: taken = (longint'(v.rs1) != longint'(v.rs2));
      3'd4: taken = (int'(v.rs1) <  int'(v.rs2));
      3'd5: taken = (int'(v.rs1) >= int'(v.rs2));
      3'd6: taken = (longint'(v.rs1) <  longint'(v.rs2));
      3'd7: taken = (longint'(v.rs1) >= longint'(v.rs2));
      default: taken = 1'b0;
    endcase
    mis = taken && (tgt % 4 != 0);
`ifdef BRANCH_BTFN_PREDICT_EN
    if (mis) begin
      redir = v.imm[31];
      rpc   = fall;
    end else begin
      redir = (taken != v.imm[31]);
      rpc   = taken ? tgt : fall;
    end
`else
    redir = taken && !mis;
    rpc   = tgt;
`endif
  endfunction

  // Drives one branch through the DUT and reports what was observed.
  task automatic applyStimulus(input vec_t v, output logic gotRedir, output logic [31:0] gotPc,
                               output logic gotMis, output int flushLen);
    flushLen = 0;
    @(negedge clk);
    checkOutput("idle_br_ready", 32'(bus.br_ready), 32'd1);
    bus.br_valid = 1'b1; bus.br_pc = v.pc; bus.br_imm = v.imm;
    bus.br_rs1 = v.rs1; bus.br_rs2 = v.rs2; bus.br_f3 = v.f3;
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    bus.br_valid = 1'b0;
    bus.br_pc = $urandom; bus.br_imm = $urandom; bus.br_rs1 = $urandom; bus.br_rs2 = $urandom;
    bus.br_f3 = 3'($urandom);
    gotMis = misalign_err;
    checkOutput("eval_br_ready", 32'(bus.br_ready), 32'd0);
    @(negedge clk);
    checkOutput("mis_pulse_len", 32'(misalign_err), 32'd0);
    gotRedir = bus.redirect_valid;
    gotPc    = bus.redirect_pc;
    if (!gotRedir) begin
      checkOutput("nt_ready_n2", 32'(bus.br_ready), 32'd1);
    end else begin
      bus.br_valid = 1'b1;
      for (int k = 0; k < v.rdyDelay; k++) begin
        @(negedge clk);
        checkOutput("hold_valid", 32'(bus.redirect_valid), 32'd1);
        checkOutput("hold_pc", bus.redirect_pc, gotPc);
        checkOutput("hold_no_flush", 32'(flush), 32'd0);
      end
      bus.redirect_ready = 1'b1;
      bus.br_valid       = 1'b0;
      @(negedge clk);
      bus.redirect_ready = 1'b0;
      checkOutput("valid_drop", 32'(bus.redirect_valid), 32'd0);
      while (flush === 1'b1 && flushLen < 40) begin
        flushLen++;
        @(negedge clk);
      end
      checkOutput("post_br_ready", 32'(bus.br_ready), 32'd1);
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    logic        r, m;
    logic [31:0] p;
    int          fl;
    applyStimulus(v, r, p, m, fl);
    resolvedModel++;
    if (v.expRedir) redirectModel++;
    checkOutput({tag, "_redirect"}, 32'(r), 32'(v.expRedir));
    checkOutput({tag, "_misalign"}, 32'(m), 32'(v.expMis));
    if (v.expRedir) begin
      checkOutput({tag, "_pc"}, p, v.expPc);
      checkOutput({tag, "_flush_len"}, 32'(fl), 32'(FLUSH_CYC));
    end
    checkOutput({tag, "_resolved_cnt"}, 32'(resolved_cnt),
                32'((resolvedModel > CNT_MAX) ? CNT_MAX : resolvedModel));
    checkOutput({tag, "_redirect_cnt"}, 32'(redirect_cnt),
                32'((redirectModel > CNT_MAX) ? CNT_MAX : redirectModel));
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [31:0] r;
    logic        er, em;
    logic [31:0] ep;

`ifndef BRANCH_BTFN_PREDICT_EN
    vecs.push_back('{32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 0, 1'b1, 32'h120, 1'b0});
    vecs.push_back('{32'h100, 32'h20, 32'd7, 32'd7, 3'b001, 0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{32'h100, 32'h40, 32'hFFFFFFFF, 32'd1, 3'b100, 0, 1'b1, 32'h140, 1'b0});
    vecs.push_back('{32'h100, 32'h40, 32'hFFFFFFFF, 32'd1, 3'b110, 0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 5, 1'b1, 32'h120, 1'b0});
    vecs.push_back('{32'hFFFFFFFC, 32'h8, 32'd0, 32'd0, 3'b111, 1, 1'b1, 32'h4, 1'b0});
    vecs.push_back('{32'hFFFFFFFC, 32'h6, 32'd0, 32'd0, 3'b111, 0, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{32'h100, 32'h20, 32'd3, 32'd3, 3'b010, 0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{32'h1000, 32'hFFFFFFF0, 32'd1, 32'hFFFFFFFF, 3'b101, 2, 1'b1, 32'hFF0, 1'b0});
    vecs.push_back('{32'h1000, 32'hFFFFFFF0, 32'd1, 32'hFFFFFFFF, 3'b111, 0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{32'h100, 32'h20, 32'd9, 32'd9, 3'b011, 0, 1'b0, 32'h0, 1'b0});
`else
    vecs.push_back('{32'h200, 32'hFFFFFFF0, 32'd5, 32'd5, 3'b000, 0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{32'h200, 32'hFFFFFFF0, 32'd5, 32'd5, 3'b001, 0, 1'b1, 32'h204, 1'b0});
    vecs.push_back('{32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 3, 1'b1, 32'h120, 1'b0});
    vecs.push_back('{32'h100, 32'h20, 32'd5, 32'd6, 3'b000, 0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{32'h200, 32'hFFFFFFFE, 32'd5, 32'd5, 3'b000, 0, 1'b1, 32'h204, 1'b1});
    vecs.push_back('{32'h100, 32'h6, 32'd5, 32'd5, 3'b000, 0, 1'b0, 32'h0, 1'b1});
`endif

    rst_n = 1'b0;
    bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_imm = '0; bus.br_rs1 = '0; bus.br_rs2 = '0;
    bus.br_f3 = '0; bus.redirect_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 32'd0);
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
    checkOutput("rst_resolved_cnt", 32'(resolved_cnt), 32'd0);
    checkOutput("rst_redirect_cnt", 32'(redirect_cnt), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) runVector(vecs[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      v.pc  = (n % 8 == 7) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      v.imm = {{20{r[11]}}, r[11:0]};
      if ($urandom_range(0, 3) != 0) v.imm[1:0] = 2'b00;
      v.rs1 = $urandom;
      v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : 32'($urandom);
      v.f3  = 3'($urandom);
      v.rdyDelay = $urandom_range(0, 3);
      refModel(v, er, ep, em);
      v.expRedir = er; v.expPc = ep; v.expMis = em;
      runVector(v, $sformatf("rnd%0d", n));
    end

    // Reset while a redirect is waiting for fetch.
    @(negedge clk);
    bus.br_valid = 1'b1; bus.br_pc = 32'h300; bus.br_imm = 32'h10;
    bus.br_rs1 = 32'd5; bus.br_rs2 = 32'd5; bus.br_f3 = 3'b000;
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    bus.br_valid = 1'b0;
    @(negedge clk);
    checkOutput("rr_pre_valid", 32'(bus.redirect_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rr_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rr_pc", bus.redirect_pc, 32'd0);
    checkOutput("rr_flush", 32'(flush), 32'd0);
    checkOutput("rr_resolved_cnt", 32'(resolved_cnt), 32'd0);
    checkOutput("rr_redirect_cnt", 32'(redirect_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rr_br_ready", 32'(bus.br_ready), 32'd1);
    resolvedModel = 0;
    redirectModel = 0;
    runVector(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
